// File: rtl/osg_cfg_pkg.sv
// Shared constants, state encoding and byte helpers for the configuration frame loader.
package osg_cfg_pkg;

    localparam logic [7:0]  HDR_CH           = 8'hA5;
    localparam logic [7:0]  HDR_START        = 8'h5A;
    localparam int unsigned DEF_NUM_CH       = 16;
    localparam int unsigned DEF_BYTES_PER_CH = 6;

    typedef enum logic [2:0] {
        IDLE,
        INDEX,
        PAYLOAD,
        CHECK,
        WRITE
    } cfg_state_e;

    // Host sends bytes LSB-first, so bit 0 on the wire lands in bit 7.
    function automatic logic [7:0] bit_rev8(input logic [7:0] v);
        logic [7:0] r;
        r = '0;
        for (int i = 0; i < 8; i++) begin
            r[i] = v[7-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/cfg_frame_loader_if.sv
// Byte input from the UART receiver and byte-wide write port into the channel-parameter RAM.
interface cfg_frame_loader_if #(
    parameter int unsigned ADDR_W = 8
);
    // rx_valid is a single-cycle strobe with no back-pressure: rx_data is consumed on the
    // cycle rx_valid is high or not at all. wr_en is likewise a strobe; the RAM accepts
    // wr_addr/wr_data on every cycle wr_en is high and never stalls the writer.
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;

    modport master (
        input  rx_data,
        input  rx_valid,
        output wr_en,
        output wr_addr,
        output wr_data
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

endinterface

// File: rtl/cfg_byte_timer.sv
// Inter-byte idle counter; tc_o flags the cycle in which the idle gap reaches TIMEOUT_CYC.
module cfg_byte_timer #(
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    output logic tc_o
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);

    logic [CW-1:0] count_q;
    logic [CW-1:0] count_d;

    // count_q holds the number of idle edges already seen, so the edge that would make it
    // TIMEOUT_CYC is the one where tc_o is high.
    assign tc_o = en_i && (count_q == CW'(TIMEOUT_CYC - 1));

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && !tc_o) begin
            count_d = count_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/cfg_frame_loader.sv
// Parses checksummed host frames and burst-writes one channel's parameter block into RAM,
// so a corrupted or truncated stream never leaves a channel partially updated.
module cfg_frame_loader
    import osg_cfg_pkg::*;
#(
    parameter int unsigned NUM_CH       = DEF_NUM_CH,
    parameter int unsigned BYTES_PER_CH = DEF_BYTES_PER_CH,
    parameter int unsigned ADDR_W       = 8,
    parameter int unsigned TIMEOUT_CYC  = 50000,
    parameter int unsigned BIT_REVERSE  = 1
) (
    input  logic               clk,
    input  logic               rst,
    cfg_frame_loader_if.master bus,
    output logic               cfg_start,
    output logic               frame_ok,
    output logic               err_csum,
    output logic               err_index,
    output logic               err_timeout,
    output logic               err_overrun,
    output logic               busy,
    output cfg_state_e         state_dbg
);

    localparam int unsigned CNT_W = (BYTES_PER_CH > 1) ? $clog2(BYTES_PER_CH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BYTES_PER_CH - 1);

    if (NUM_CH * BYTES_PER_CH > 2 ** ADDR_W) begin : g_addr_chk
        $error("cfg_frame_loader: NUM_CH*BYTES_PER_CH exceeds the RAM address space");
    end

    cfg_state_e        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        csum_q, csum_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [7:0]        pbuf_q [BYTES_PER_CH];
    logic [7:0]        pbuf_d [BYTES_PER_CH];
    logic              cfg_start_q, cfg_start_d;
    logic              err_csum_q, err_csum_d;
    logic              err_index_q, err_index_d;
    logic              err_timeout_q, err_timeout_d;
    logic              err_overrun_q, err_overrun_d;
    logic              busy_q;

    logic [7:0] b;
    logic       in_frame;
    logic       tmr_tc;
    logic       writing;

    assign b        = (BIT_REVERSE != 0) ? bit_rev8(bus.rx_data) : bus.rx_data;
    assign in_frame = (state_q == INDEX) || (state_q == PAYLOAD) || (state_q == CHECK);

    // Any byte restarts the idle count, so a byte on the terminal cycle beats the timeout.
    cfg_byte_timer #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .clr_i (bus.rx_valid || !in_frame),
        .en_i  (in_frame),
        .tc_o  (tmr_tc)
    );

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        csum_d        = csum_q;
        base_d        = base_q;
        pbuf_d        = pbuf_q;
        cfg_start_d   = 1'b0;
        err_csum_d    = 1'b0;
        err_index_d   = 1'b0;
        err_timeout_d = 1'b0;
        err_overrun_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.rx_valid) begin
                    if (b == HDR_CH) begin
                        state_d = INDEX;
                    end else if (b == HDR_START) begin
                        cfg_start_d = 1'b1;
                    end
                end
            end
            INDEX: begin
                if (bus.rx_valid) begin
                    if (32'(b) < NUM_CH) begin
                        base_d  = ADDR_W'(ADDR_W'(b) * ADDR_W'(BYTES_PER_CH));
                        csum_d  = b;
                        cnt_d   = '0;
                        state_d = PAYLOAD;
                    end else begin
                        err_index_d = 1'b1;
                        state_d     = IDLE;
                    end
                end else if (tmr_tc) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            PAYLOAD: begin
                if (bus.rx_valid) begin
                    pbuf_d[cnt_q] = b;
                    csum_d        = csum_q ^ b;
                    if (cnt_q == LAST) begin
                        cnt_d   = '0;
                        state_d = CHECK;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (tmr_tc) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            CHECK: begin
                if (bus.rx_valid) begin
                    if (b == csum_q) begin
                        cnt_d   = '0;
                        state_d = WRITE;
                    end else begin
                        err_csum_d = 1'b1;
                        state_d    = IDLE;
                    end
                end else if (tmr_tc) begin
                    err_timeout_d = 1'b1;
                    state_d       = IDLE;
                end
            end
            WRITE: begin
                err_overrun_d = bus.rx_valid;
                if (cnt_q == LAST) begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            csum_q        <= '0;
            base_q        <= '0;
            pbuf_q        <= '{default: 8'h00};
            cfg_start_q   <= 1'b0;
            err_csum_q    <= 1'b0;
            err_index_q   <= 1'b0;
            err_timeout_q <= 1'b0;
            err_overrun_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            csum_q        <= csum_d;
            base_q        <= base_d;
            pbuf_q        <= pbuf_d;
            cfg_start_q   <= cfg_start_d;
            err_csum_q    <= err_csum_d;
            err_index_q   <= err_index_d;
            err_timeout_q <= err_timeout_d;
            err_overrun_q <= err_overrun_d;
            busy_q        <= (state_d != IDLE);
        end
    end

    // Write port is driven straight from the burst registers and forced to zero outside WRITE.
    assign writing     = (state_q == WRITE);
    assign bus.wr_en   = writing;
    assign bus.wr_addr = writing ? (base_q + ADDR_W'(cnt_q)) : '0;
    assign bus.wr_data = writing ? pbuf_q[cnt_q] : '0;
    assign frame_ok    = writing && (cnt_q == LAST);

    assign cfg_start   = cfg_start_q;
    assign err_csum    = err_csum_q;
    assign err_index   = err_index_q;
    assign err_timeout = err_timeout_q;
    assign err_overrun = err_overrun_q;
    assign busy        = busy_q;
    assign state_dbg   = state_q;

endmodule
